left_shift_x16_pipe: RTL

Pipelined 16-bit left rotator/shifter with valid/ready handshake. It is the left-direction counterpart of the combinational 16-bit right rotator in the ALU shift path. It accepts one operand pair per cycle and returns the result four cycles later through a log-shifter pipeline (1, 2, 4, 8). Backpressure from the consumer stalls the whole pipeline without losing or duplicating data.

---
 rtl/left_shift_x16_pipe_if.sv | 35 +++
 rtl/left_shift_x16_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/left_shift_x16_pipe_if.sv
// Handshake bundle for the pipelined 16-bit left rotator/shifter.
// The ovf member exists only when LSX16_OVF_EN is defined.
interface left_shift_x16_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef LSX16_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, rot, out_ready,
    input  in_ready, out_valid,
`ifdef LSX16_OVF_EN
           ovf,
`endif
           out
  );

  modport slave (
    input  in_valid, a, b, rot, out_ready,
    output in_ready, out_valid,
`ifdef LSX16_OVF_EN
           ovf,
`endif
           out
  );
endinterface

// File: rtl/left_shift_x16_pipe.sv
// Four-stage log shifter (1, 2, 4, 8) doing rotate or logical shift left with a
// valid/ready handshake; LSX16_OVF_EN adds a sticky shifted-out flag (ovf).
module left_shift_x16_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  left_shift_x16_pipe_if.slave bus
);
  localparam int AW     = 4;
  localparam int STAGES = 4;

  logic adv;
  logic last_valid;

  // A single enable moves every stage together, so a stall can never split a packet.
  assign adv          = ~last_valid | bus.out_ready;
  assign bus.in_ready = adv;

  logic unused_b;
  assign unused_b = &{1'b0, bus.b[WIDTH-1:AW]};

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int DIST = 1 << gi;
      // Amount bits still pending on entry; bit 0 is the one this stage consumes.
      localparam int RW   = AW - gi;

      logic             st_valid;
      logic [WIDTH-1:0] st_data;
      logic [RW-1:0]    st_amt;
      logic             st_rot;
      logic [WIDTH-1:0] data_next;
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
`ifdef LSX16_OVF_EN
      logic             st_ovf;
      logic             ovf_next;
      logic             ovf_reg;
`endif

      if (gi == 0) begin : g_src
        assign st_valid = bus.in_valid;
        assign st_data  = bus.a;
        assign st_amt   = bus.b[AW-1:0];
        assign st_rot   = bus.rot;
`ifdef LSX16_OVF_EN
        assign st_ovf   = 1'b0;
`endif
      end else begin : g_src
        assign st_valid = g_stage[gi-1].valid_reg;
        assign st_data  = g_stage[gi-1].data_reg;
        assign st_amt   = g_stage[gi-1].g_carry.amt_reg;
        assign st_rot   = g_stage[gi-1].g_carry.rot_reg;
`ifdef LSX16_OVF_EN
        assign st_ovf   = g_stage[gi-1].ovf_reg;
`endif
      end

      always_comb begin
        data_next = st_data;
        if (st_amt[0]) begin
          if (st_rot) begin
            data_next = {st_data[WIDTH-1-DIST:0], st_data[WIDTH-1 -: DIST]};
          end else begin
            data_next = {st_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
          end
        end
      end

`ifdef LSX16_OVF_EN
      // Only bits lost in shift mode count; rotate keeps every bit.
      assign ovf_next = st_ovf | (~st_rot & st_amt[0] & (|st_data[WIDTH-1 -: DIST]));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= ovf_next;
        end
      end
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (adv) begin
          valid_reg <= st_valid;
          data_reg  <= data_next;
        end
      end

      // The last stage needs neither the mode nor any remaining amount bits.
      if (gi < STAGES - 1) begin : g_carry
        logic [RW-2:0] amt_reg;
        logic          rot_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            amt_reg <= '0;
            rot_reg <= 1'b0;
          end else if (adv) begin
            amt_reg <= st_amt[RW-1:1];
            rot_reg <= st_rot;
          end
        end
      end
    end
  endgenerate

  assign last_valid    = g_stage[STAGES-1].valid_reg;
  assign bus.out_valid = last_valid;
  assign bus.out       = g_stage[STAGES-1].data_reg;
`ifdef LSX16_OVF_EN
  assign bus.ovf       = g_stage[STAGES-1].ovf_reg;
`endif

endmodule
